// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - ascending row scanner driving a 3-to-8 decoder
//
// Purpose:
//   Walks the set bits of an 8-bit row mask in ascending order and drives the
//   decoder enable/select for each one. Each row gets BLANK_CYCLES cycles with
//   en low (sel already settled), followed by max(dwell,1) cycles with en high.
//   A start/busy/done handshake launches one pass and reports its end.
//
// Build option:
//   SCAN_CONTINUOUS_EN - when defined, a pass that ends while start is high
//   wraps straight into a new pass using a freshly latched row_mask/dwell.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   launch request, honoured only while idle
//   dwell      in   [DWELL_W] active cycles per row (0 behaves as 1), latched at start
//   row_mask   in   [8] rows to scan, latched at start
//   en         out  registered decoder enable
//   sel        out  [3] registered decoder row select
//   row_strobe out  pulse in the first active cycle of each row
//   busy       out  high while a pass is in progress
//   done       out  one-cycle end-of-pass pulse

module decoder_scan_sequencer #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         row_mask,
  output logic               en,
  output logic [2:0]         sel,
  output logic               row_strobe,
  output logic               busy,
  output logic               done
);

  // Blank counter holds "cycles remaining after this one", so it only needs
  // to reach BLANK_CYCLES-1. Kept at least one bit wide for the zero case.
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD =
    (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic                 en_q, en_d;
  logic [2:0]           sel_q, sel_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Row-entry request shared by every path that starts a new row.
  logic                 begin_row;
  logic [DWELL_W-1:0]   begin_dwell;
  logic [3:0]           nxt;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] lowest_row(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest set bit strictly above cur. Never wraps.
  function automatic logic [3:0] next_row(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;
    en_d        = 1'b0;
    sel_d       = sel_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    begin_row   = 1'b0;
    begin_dwell = dwell_q;
    nxt         = next_row(mask_q, sel_q);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (row_mask != 8'h00) begin
            mask_d      = row_mask;
            dwell_d     = dwell;
            sel_d       = lowest_row(row_mask);
            busy_d      = 1'b1;
            begin_row   = 1'b1;
            begin_dwell = dwell;
          end else begin
            // Empty pass: report completion immediately, never enable.
            done_d = 1'b1;
          end
        end
      end

      S_BLANK: begin
        if (blank_cnt_q == '0) begin
          state_d     = S_ACTIVE;
          en_d        = 1'b1;
          strobe_d    = 1'b1;
          dwell_cnt_d = eff_dwell(dwell_q);
        end else begin
          blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end
      end

      S_ACTIVE: begin
        en_d = 1'b1;
        // Counter is loaded with at least 1 and stops at 1; a stray 0 is
        // also treated as the last cycle so it can never wrap.
        if (dwell_cnt_q > DWELL_W'(1)) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end else if (nxt[3]) begin
          sel_d       = nxt[2:0];
          en_d        = 1'b0;
          begin_row   = 1'b1;
          begin_dwell = dwell_q;
        end else begin
          en_d   = 1'b0;
          done_d = 1'b1;
`ifdef SCAN_CONTINUOUS_EN
          if (start && (row_mask != 8'h00)) begin
            mask_d      = row_mask;
            dwell_d     = dwell;
            sel_d       = lowest_row(row_mask);
            begin_row   = 1'b1;
            begin_dwell = dwell;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Entering a row: either a blank phase with en low, or, with no blanking,
    // straight into the active phase (sel and en change together).
    if (begin_row) begin
      if (BLANK_CYCLES > 0) begin
        state_d     = S_BLANK;
        blank_cnt_d = BLANK_LOAD;
        en_d        = 1'b0;
      end else begin
        state_d     = S_ACTIVE;
        en_d        = 1'b1;
        strobe_d    = 1'b1;
        dwell_cnt_d = eff_dwell(begin_dwell);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      blank_cnt_q <= '0;
      en_q        <= 1'b0;
      sel_q       <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign en         = en_q;
  assign sel        = sel_q;
  assign row_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder: produces `en` and `sel[2:0]` to scan the enabled rows of an 8-row group in ascending order.
- Each active row is held for a programmable dwell, with blanking cycles between rows so `sel` never changes while `en` is high.
- Start/busy/done handshake lets a controller launch one pass and detect its end.
- Outputs connect directly to the decoder's enable and 3-bit input.

Parameters:
- DWELL_W, 8, width of the dwell-count input.
- BLANK_CYCLES, 1, number of `en`-low cycles before each active row (0 allowed).

Ports:
- clk        input   1        system clock, all logic on rising edge
- reset      input   1        synchronous, active-high reset
- start      input   1        launch request, sampled in IDLE only
- dwell      input   DWELL_W  active cycles per row, latched at start; 0 treated as 1
- row_mask   input   8        bit i=1 means row i is scanned; latched at start
- en         output  1        decoder enable, registered
- sel        output  3        decoder row select, registered
- row_strobe output  1        1-cycle pulse in the first active cycle of each row
- busy       output  1        high from the cycle after start is accepted until done
- done       output  1        1-cycle pulse marking the end of a pass

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`).
- All outputs are registered.
  - Reset values: en=0, sel=0, row_strobe=0, busy=0, done=0, state=IDLE.
  - Reset mid-pass aborts at the next edge with no done pulse.
- States: IDLE, BLANK, ACTIVE.
  - IDLE: waits for start=1.
    - On start with row_mask≠0: latch mask and dwell, set sel to the lowest set mask bit, busy=1.
    - Next state is BLANK if BLANK_CYCLES>0, else ACTIVE.
    - On start with row_mask=0: done=1 for one cycle, busy stays 0, en is never asserted.
  - BLANK: en=0, sel held, for exactly BLANK_CYCLES cycles, then ACTIVE.
  - ACTIVE: en=1, sel held, for exactly max(dwell,1) cycles. row_strobe=1 in the first of them.
    - At the last active cycle, search the latched mask for the next set bit above sel.
    - If found: sel takes that index and the FSM returns to BLANK, or stays ACTIVE with a new row_strobe when BLANK_CYCLES=0.
    - If none: go to IDLE. In the next cycle done=1, busy=0, en=0, and sel keeps the last row.
- sel only changes in a cycle where en is, or is becoming, 0.
  - Exception: with BLANK_CYCLES=0, sel and the new row change together at a row boundary while en stays 1.
- Dwell counter is DWELL_W bits and counts down with no wrap.
- Changes to row_mask or dwell during a pass have no effect.
- start while busy is ignored.
- start high in the same cycle done pulses is accepted on the following edge (back-to-back passes allowed).
- Row 7 as the last masked row ends the pass; the search never wraps unless the optional feature is compiled in.

Optional Feature:
- Macro: SCAN_CONTINUOUS_EN.
- Defined:
  - At end of pass, if start is high, the scan wraps to the lowest masked bit of a freshly re-latched row_mask/dwell without returning to IDLE.
  - done still pulses once per pass and busy stays 1.
  - If start is low, or the new mask is 0, it behaves as the single-pass end.
- Undefined: strictly single pass; start must be re-asserted from IDLE.

Test Plan:
- BLANK_CYCLES=1, dwell=3, mask=8'b0000_0101, start pulsed at edge 0.
  - Cycle 1: blank, sel=0.
  - Cycles 2-4: en=1, sel=0; row_strobe in cycle 2.
  - Cycle 5: blank, sel=2.
  - Cycles 6-8: en=1, sel=2.
  - Cycle 9: done=1, busy=0.
  - Total en-high cycles = 6.
- mask=8'h00, start -> done=1 one cycle later; busy and en never high.
- dwell=0, mask=8'h80, BLANK_CYCLES=1 -> one blank cycle, one en cycle with sel=7, then done.
- mask=8'hFF, dwell=2; reset asserted while sel=4 and en=1 -> next edge en=0, sel=0, busy=0; no done pulse.
- start re-asserted and row_mask changed during busy -> ignored; pass completes with the original mask.
- SCAN_CONTINUOUS_EN defined, start held high, mask=8'b1000_0010 -> sel sequence 1,7,1,7…; done pulses after each sel=7 row.
